// File: rtl/osd_host_reg_reader_if.sv
// GLIP word channel: 16-bit data with a valid/ready handshake.
// The master drives data and valid, and the slave drives ready.
// A word transfers on every rising edge where valid && ready.
interface osd_host_reg_reader_if;
   logic [15:0] data;
   logic        valid;
   logic        ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/osd_host_reg_reader.sv
// Host-side debug register read engine on a GLIP link.
// A start pulse sends one length-prefixed REG read request:
//    4, dest, SRC_ID, 16'h0000, addr
// The engine then watches returning frames for the matching response.
// It reports read data, a module error, or a timeout on a one-cycle done pulse.
// The receive parser always tracks framing, whatever the request state is.
// Frames that arrive while no request is waiting are drained and dropped.
module osd_host_reg_reader #(
   parameter logic [15:0] SRC_ID  = 16'h0000,
   parameter int          TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [15:0]                   dest,
   input  logic [15:0]                   addr,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic                          timeout,
   output logic [15:0]                   rdata,
   osd_host_reg_reader_if.master         glip_out,
   osd_host_reg_reader_if.slave          glip_in
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
   localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] TYPE_REG    = 2'b00;
   localparam logic [3:0] SUB_RD_OK   = 4'h8;
   localparam logic [3:0] SUB_RD_ERR  = 4'hC;

   logic [1:0]    state_reg, state_next;
   logic [2:0]    tx_idx_reg;
   logic [15:0]   dest_reg;
   logic [15:0]   addr_reg;
   logic [CW-1:0] to_cnt_reg;
   logic          error_reg;
   logic          timeout_reg;
   logic [15:0]   rdata_reg;

   // Receive parser state.
   logic          rx_in_frame_reg;
   logic [15:0]   rx_len_reg;
   logic [15:0]   rx_pos_reg;
   logic [15:0]   rx_dst_reg;     // body word 1
   logic [15:0]   rx_src_reg;     // body word 2
   logic [5:0]    rx_flags_reg;   // body word 3, type and subtype bits only

   logic          tx_accept;
   logic          tx_last;
   logic          rx_accept;
   logic          rx_frame_end;
   logic          hdr_match;
   logic          rd_ok;
   logic          rd_err;
   logic          to_expire;
   logic [15:0]   tx_data;

   assign tx_accept = glip_out.valid && glip_out.ready;
   assign tx_last   = tx_accept && (tx_idx_reg == 3'd4);

   // Receive is always enabled, except while reset is held.
   assign glip_in.ready = ~rst;
   assign rx_accept     = glip_in.valid && glip_in.ready;

   // The current word closes a frame when it is body word number L.
   assign rx_frame_end = rx_accept && rx_in_frame_reg && (rx_pos_reg == rx_len_reg);

   assign hdr_match = (rx_dst_reg == SRC_ID) && (rx_src_reg == dest_reg);

   // A read success is 4 words long, so its flags were captured one word earlier.
   assign rd_ok  = rx_frame_end && (rx_len_reg == 16'd4) && hdr_match
                   && (rx_flags_reg[5:4] == TYPE_REG)
                   && (rx_flags_reg[3:0] == SUB_RD_OK);
   // A read error is 3 words long, so the flags word is the closing word.
   assign rd_err = rx_frame_end && (rx_len_reg == 16'd3) && hdr_match
                   && (glip_in.data[15:14] == TYPE_REG)
                   && (glip_in.data[13:10] == SUB_RD_ERR);

   assign to_expire = (to_cnt_reg == TO_LAST);

   // Request word mux, driven from registered index and captured fields so
   // the presented word cannot change while it waits for ready.
   always_comb begin
      tx_data = 16'h0000;
      case (tx_idx_reg)
         3'd0:    tx_data = 16'd4;
         3'd1:    tx_data = dest_reg;
         3'd2:    tx_data = SRC_ID;
         3'd3:    tx_data = 16'h0000;
         3'd4:    tx_data = addr_reg;
         default: tx_data = 16'h0000;
      endcase
   end

   assign glip_out.data  = tx_data;
   assign glip_out.valid = (state_reg == ST_SEND);

   assign busy    = (state_reg != ST_IDLE);
   assign done    = (state_reg == ST_DONE);
   assign error   = error_reg;
   assign timeout = timeout_reg;
   assign rdata   = rdata_reg;

   // Next-state logic for the request engine.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_SEND;
         ST_SEND: if (tx_last) state_next = ST_WAIT;
         ST_WAIT: if (rd_ok || rd_err || to_expire) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register, plus request capture and transmit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         tx_idx_reg <= 3'd0;
         dest_reg   <= 16'h0000;
         addr_reg   <= 16'h0000;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && start) begin
            dest_reg   <= dest;
            addr_reg   <= addr;
            tx_idx_reg <= 3'd0;
         end else if (state_reg == ST_SEND && tx_accept && !tx_last) begin
            tx_idx_reg <= tx_idx_reg + 3'd1;
         end
      end
   end

   // Timeout counter: held at zero until WAIT, then counts WAIT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
         if (!to_expire) to_cnt_reg <= to_cnt_reg + 1'b1;
      end else begin
         to_cnt_reg <= '0;
      end
   end

   // Result registers: set on entry to DONE and held until the next completion.
   // A match in the expiry cycle takes priority over the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         rdata_reg   <= 16'h0000;
      end else if (state_reg == ST_WAIT) begin
         if (rd_ok) begin
            rdata_reg   <= glip_in.data;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;
         end else if (rd_err) begin
            error_reg   <= 1'b1;
            timeout_reg <= 1'b0;
         end else if (to_expire) begin
            error_reg   <= 1'b0;
            timeout_reg <= 1'b1;
         end
      end
   end

   // Receive framing. A length word opens a frame, unless L is zero. Body
   // words are counted until word L closes the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_in_frame_reg <= 1'b0;
         rx_len_reg      <= 16'h0000;
         rx_pos_reg      <= 16'h0000;
      end else if (rx_accept) begin
         if (!rx_in_frame_reg) begin
            rx_len_reg <= glip_in.data;
            rx_pos_reg <= 16'd1;
            if (glip_in.data != 16'h0000) rx_in_frame_reg <= 1'b1;
         end else if (rx_pos_reg == rx_len_reg) begin
            rx_in_frame_reg <= 1'b0;
         end else begin
            rx_pos_reg <= rx_pos_reg + 16'd1;
         end
      end
   end

   // Capture the header words of the frame currently being received.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_dst_reg   <= 16'h0000;
         rx_src_reg   <= 16'h0000;
         rx_flags_reg <= 6'd0;
      end else if (rx_accept && rx_in_frame_reg) begin
         case (rx_pos_reg)
            16'd1:   rx_dst_reg   <= glip_in.data;
            16'd2:   rx_src_reg   <= glip_in.data;
            16'd3:   rx_flags_reg <= glip_in.data[15:10];
            default: ;
         endcase
      end
   end

endmodule
